// File: rtl/alu_mul_seq.sv
// Shift-and-add 16x16 multiply sequencer that drives the shared execute-stage ALU.
// MUL_EARLY_EXIT_EN: ends the run when the remaining multiplier is zero, and skips the run when opb==0.
module alu_mul_seq #(
  parameter int DSIZE = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DSIZE-1:0] opa,
  input  logic [DSIZE-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [DSIZE-1:0] result,
  output logic             ovf,
  output logic [DSIZE-1:0] alu_a,
  output logic [DSIZE-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic [3:0]       alu_imm,
  output logic             alu_nop,
  input  logic [DSIZE-1:0] alu_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  localparam logic [2:0]       OP_ADD   = 3'd0;
  localparam logic [2:0]       OP_SLL   = 3'd4;
  localparam logic [2:0]       OP_SRL   = 3'd5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DSIZE - 1);

  state_t           state, state_nx;
  logic [DSIZE-1:0] prod, mcand, mplier;
  logic [CNT_W-1:0] cnt;
  logic             ovf_acc;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = OP_ADD;
    alu_imm  = '0;
    alu_nop  = 1'b1;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef MUL_EARLY_EXIT_EN
          state_nx = (opb == '0) ? S_DONE : S_ADD;
`else
          state_nx = S_ADD;
`endif
        end
      end
      S_ADD: begin
        busy     = 1'b1;
        alu_nop  = 1'b0;
        alu_op   = OP_ADD;
        alu_a    = prod;
        alu_b    = mcand;
        state_nx = S_SHL;
      end
      S_SHL: begin
        busy     = 1'b1;
        alu_nop  = 1'b0;
        alu_op   = OP_SLL;
        alu_a    = mcand;
        alu_imm  = 4'd1;
        state_nx = S_SHR;
      end
      S_SHR: begin
        busy    = 1'b1;
        alu_nop = 1'b0;
        alu_op  = OP_SRL;
        alu_a   = mplier;
        alu_imm = 4'd1;
`ifdef MUL_EARLY_EXIT_EN
        state_nx = (cnt == CNT_LAST || alu_out == '0) ? S_DONE : S_ADD;
`else
        state_nx = (cnt == CNT_LAST) ? S_DONE : S_ADD;
`endif
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prod    <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
      result  <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand   <= opa;
            mplier  <= opb;
            prod    <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            result  <= '0;
            ovf     <= 1'b0;
          end
        end
        S_ADD: begin
          if (mplier[0]) begin
            prod <= alu_out;
            if (alu_out < prod) ovf_acc <= 1'b1;
          end
        end
        S_SHL: begin
          mcand <= alu_out;
          // a multiplicand bit leaving the word still has multiplier bits left to meet
          if (mcand[DSIZE-1] && (mplier >> 1) != '0) ovf_acc <= 1'b1;
        end
        S_SHR: begin
          mplier <= alu_out;
          cnt    <= cnt + 1'b1;
          if (state_nx == S_DONE) begin
            result <= prod;
            ovf    <= ovf_acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: a behavioural ALU plus a plain-arithmetic product model.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] opa = '0, opb = '0;
  logic        busy, done, ovf, alu_nop;
  logic [15:0] result, alu_a, alu_b, alu_out;
  logic [2:0]  alu_op;
  logic [3:0]  alu_imm;

  alu_mul_seq #(.DSIZE(16), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .ovf(ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_imm(alu_imm),
    .alu_nop(alu_nop), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_out = '0;
    if (!alu_nop) begin
      case (alu_op)
        3'd0:    alu_out = alu_a + alu_b;
        3'd4:    alu_out = alu_a << alu_imm;
        3'd5:    alu_out = alu_a >> alu_imm;
        default: alu_out = '0;
      endcase
    end
  end

  typedef struct {
    logic [15:0] res;
    logic        ov;
    int          k;
    int          lat;
    int          busy_len;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;
  int   checks = 0, fails = 0, cyc = 0, busy_cnt = 0, unused_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Latency is counted from the accepting edge to the edge that enters DONE.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int k);
    exp_t        e;
    logic [31:0] p;
    int          h;
    p = {16'h0, a} * {16'h0, b};
    e.res = p[15:0];
    e.ov  = (p > 32'h0000_FFFF);
    e.k   = k;
    h = -1;
    for (int i = 0; i < 16; i++) if (b[i]) h = i;
`ifdef MUL_EARLY_EXIT_EN
    e.busy_len = 3 * (h + 1);
`else
    e.busy_len = 48;
`endif
    e.lat = e.busy_len;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (busy) begin
        busy_cnt++;
        if (alu_op == 3'd0 && alu_imm != 4'd0) unused_bad++;
        if (alu_op != 3'd0 && alu_b != 16'd0) unused_bad++;
      end
      if (done) begin
        chk("done_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("ovf", ovf, e.ov);
          chk("latency", cyc - e.k, e.lat);
          chk("busy_cycles", busy_cnt, e.busy_len);
          chk("unused_alu_inputs", unused_bad, 0);
        end
        busy_cnt   = 0;
        unused_bad = 0;
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    @(posedge clk);
    #1 opa = a; opb = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    last_e = model(a, b, cyc);
    sb.push_back(last_e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 0, 1);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b);
    issue(a, b);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("held_result", result, last_e.res);
    chk("held_ovf", ovf, last_e.ov);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_alu_nop", alu_nop, 1);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    rst = 1'b1;

    run_op(16'd5, 16'd3);
    run_op(16'hFFFF, 16'h0001);
    run_op(16'h0100, 16'h0100);
    run_op(16'h8001, 16'h0003);
    run_op(16'h0007, 16'h0001);
    run_op(16'h1234, 16'h0000);
    run_op(16'h0000, 16'hFFFF);
    run_op(16'hFFFF, 16'hFFFF);

    for (int i = 0; i < 24; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 2 == 0) begin
        a = a & 16'h00FF;
        b = b & 16'h00FF;
      end
      run_op(a, b);
    end

    // Start held high with changing operands for the whole run.
    @(posedge clk);
    #1 opa = 16'h1234; opb = 16'h0025; start = 1'b1;
    @(posedge clk);
    #1;
    last_e = model(16'h1234, 16'h0025, cyc);
    sb.push_back(last_e);
    n = 0;
    while (!done && n < 100) begin
      opa = 16'($urandom);
      opb = 16'($urandom) | 16'h0001;
      @(posedge clk);
      #1;
      n++;
    end
    chk("held_start_done_seen", done, 1);
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();
    repeat (60) @(posedge clk);
    #1;
    chk("held_start_result", result, last_e.res);

    // Reset at iteration 7 aborts the run with no done.
    issue(16'h00FF, 16'h0F0F);
    repeat (21) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    busy_cnt   = 0;
    unused_bad = 0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_ovf", ovf, 0);
    chk("abort_alu_nop", alu_nop, 1);
    chk("abort_alu_a", alu_a, 0);
    repeat (60) @(posedge clk);
    run_op(16'h0123, 16'h0045);
    run_op(16'h4000, 16'h0004);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
